// File: rtl/rv_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle for the decode stage.
// slave = decode stage side, master = producer/consumer (testbench) side.
interface rv_decode_stage_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_fmt;
    logic [6:0]       out_opcode;
    logic [4:0]       out_rd;
    logic [2:0]       out_func3;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [6:0]       out_func7;
    logic [31:0]      out_imm;
    logic [CNT_W-1:0] out_count;

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_fmt, out_opcode, out_rd, out_func3,
               out_rs1, out_rs2, out_func7, out_imm, out_count
    );

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_fmt, out_opcode, out_rd, out_func3,
               out_rs1, out_rs2, out_func7, out_imm, out_count
    );
endinterface

// File: rtl/rv_decode_stage.sv
// Registered RV32 decode stage: R/I/U/illegal classification, immediate
// generation, two-entry skid buffer and a saturating retired-decode counter.
module rv_decode_stage #(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    rv_decode_stage_if.slave      bus_io
);
    typedef enum logic [1:0] {FMT_R = 2'd0, FMT_I = 2'd1, FMT_U = 2'd2, FMT_ILL = 2'd3} fmt_e;

    // The raw word is kept so every field output is a plain slice of it.
    typedef struct packed {
        fmt_e        fmt;
        logic [31:0] instr;
        logic [31:0] imm;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] w);
        dec_t d;
        d.instr = w;
        d.fmt   = FMT_ILL;
        d.imm   = 32'h0;
        case (w[6:0])
            7'h33: d.fmt = FMT_R;
            7'h13, 7'h03, 7'h67: begin
                d.fmt = FMT_I;
                d.imm = {{20{w[31]}}, w[31:20]};
            end
            7'h37, 7'h17: begin
                d.fmt = FMT_U;
                d.imm = {w[31:12], 12'h000};
            end
            default: d.fmt = FMT_ILL;
        endcase
        return d;
    endfunction

    dec_t             out_q, out_d, skid_q, skid_d;
    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dec_t             dec_in;
    logic             accept, deliver;

    assign dec_in  = decode(bus_io.in_instr);
    assign accept  = bus_io.in_valid && !skid_valid_q;
    assign deliver = out_valid_q && bus_io.out_ready;

    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        cnt_d        = cnt_q;
        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (deliver && !(&cnt_q))
                cnt_d = cnt_q + 1'b1;
            if (!out_valid_q || bus_io.out_ready) begin
                // Output slot frees up: skid entry has priority to keep order;
                // accept cannot coincide with a full skid since in_ready=0 then.
                if (skid_valid_q) begin
                    out_d        = skid_q;
                    out_valid_d  = 1'b1;
                    skid_valid_d = 1'b0;
                end else if (accept) begin
                    out_d       = dec_in;
                    out_valid_d = 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                end
            end else if (accept) begin
                skid_d       = dec_in;
                skid_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus_io.in_ready   = !skid_valid_q;
    assign bus_io.out_valid  = out_valid_q;
    assign bus_io.out_fmt    = out_q.fmt;
    assign bus_io.out_opcode = out_q.instr[6:0];
    assign bus_io.out_rd     = out_q.instr[11:7];
    assign bus_io.out_func3  = out_q.instr[14:12];
    assign bus_io.out_rs1    = out_q.instr[19:15];
    assign bus_io.out_rs2    = out_q.instr[24:20];
    assign bus_io.out_func7  = out_q.instr[31:25];
    assign bus_io.out_imm    = out_q.imm;
    assign bus_io.out_count  = cnt_q;
endmodule

// File: doc/rv_decode_stage.md
# rv_decode_stage

Registered RISC-V decode stage between the instruction fetch path and the execute stage. It accepts raw 32-bit instruction words over a valid/ready handshake and classifies each as R, I or U format, or illegal. It splits out the register and function fields and produces a sign-extended 32-bit immediate. A two-entry skid buffer gives full throughput under backpressure, and a saturating counter tracks retired decodes.

## Interface
- CNT_W, 16, width of the decoded-instruction counter
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous; discards all buffered instructions
- in_valid  in  1  upstream word valid
- in_ready  out  1  stage can accept a word
- in_instr  in  32  raw instruction word
- out_valid  out  1  decoded instruction valid
- out_ready  in  1  downstream accepts
- out_fmt  out  2  0=R, 1=I, 2=U, 3=illegal
- out_opcode  out  7  instr[6:0]
- out_rd  out  5  instr[11:7]
- out_func3  out  3  instr[14:12]
- out_rs1  out  5  instr[19:15]
- out_rs2  out  5  instr[24:20]
- out_func7  out  7  instr[31:25]
- out_imm  out  32  format-dependent immediate
- out_count  out  CNT_W  number of completed output handshakes, saturating

## Operation
- Input handshake: a word is accepted when in_valid && in_ready.
- Output handshake: a word is delivered when out_valid && out_ready.
- Decode is combinational on the accepted word. The decoded result is captured into the output register, or into the skid register if the output register is held.
- Format selection by opcode:
  - 7'h33 -> R
  - 7'h13, 7'h03, 7'h67 -> I
  - 7'h37, 7'h17 -> U
  - any other value, including opcode[1:0] != 2'b11 -> illegal
- Immediate generation:
  - I: {{20{instr[31]}}, instr[31:20]}
  - U: {instr[31:12], 12'h000}
  - R and illegal: 32'h0
- Field outputs (rd, rs1, rs2, func3, func7) are always the raw bit slices regardless of format. Downstream ignores the fields that do not apply.
- Illegal words are passed through with out_fmt=3. They are never dropped.
- Skid buffer behaviour:
  - When out_valid && !out_ready and a word is accepted, the word goes to the skid register.
  - in_ready = !skid_valid, taken from a register with no combinational path from out_ready.
  - When the output register drains, the skid entry moves to the output register on that same edge.
- Order is strictly preserved.
- out_count increments by 1 per output handshake and holds at all-ones.
- flush:
  - Clears out_valid and skid_valid on the next edge.
  - Any word presented in the flush cycle is dropped.
  - out_count is not affected.
  - flush has priority over a simultaneous handshake on either side. That output handshake is not counted.

## Timing
- Latency: 1 cycle. A word accepted at edge N is on the outputs with out_valid=1 after edge N.
- Throughput: 1 word/cycle while out_ready=1.
- Under backpressure, at most 2 words are held. in_ready falls the cycle after the skid register fills and rises the cycle after it empties.
- Output stability: while out_valid && !out_ready, all out_* fields hold stable.
- Reset values: out_valid=0, skid_valid=0, in_ready=1, all out_* data fields 0 (out_fmt=0), out_count=0.
- Reset asserted mid-transfer discards everything immediately and asynchronously.
- Simultaneous input and output handshakes with a full skid register cannot occur, because in_ready=0 in that state.

## Test plan
- U-format: 32'h0AA01EB7 with out_ready=1 -> next cycle out_fmt=2, out_opcode=7'h37, out_rd=29, out_imm=32'h0AA01000, out_count=1.
- I-format with sign extension: 32'hFFF00093 -> out_fmt=1, out_rd=1, out_rs1=0, out_func3=0, out_imm=32'hFFFFFFFF.
- R-format: 32'h002081B3 -> out_fmt=0, out_rd=3, out_rs1=1, out_rs2=2, out_func7=0, out_imm=0.
- Illegal: 32'h00000000 and 32'h0000007F -> out_fmt=3 for both, both delivered in order.
- Backpressure:
  - Stimulus: stream 4 words back-to-back, out_ready=0 for 3 cycles, then 1.
  - Required: in_ready drops after 2 words are held; all 4 words emerge in order with no loss or duplication; out_count=4.
- Flush and saturation:
  - With 2 words buffered, assert flush together with in_valid -> out_valid=0 and in_ready=1 next cycle; the flushed words never appear.
  - With CNT_W=4, 20 handshakes -> out_count=15.
